// File: rtl/sram_arbiter.sv
// sram_arbiter: two-requester arbiter and fixed 3-cycle access sequencer for a 1024x8 single-port SRAM
// Ports: clk, rst (synchronous, active-high)
//        a_req/a_we/a_addr/a_wdata -> a_done (1-cycle pulse), a_rdata (valid with a_done on reads); same for b_*
//        mem_address/mem_data_in/mem_write/mem_select/mem_read -> SRAM, mem_data_out <- SRAM (combinational read)
//        busy: high whenever an access is in flight
// Build option: define ARB_FIXED_PRIO_EN to make A always win simultaneous requests (B may starve);
//               left undefined, simultaneous requests are served round-robin.
module sram_arbiter #(
  parameter int ADDR_SIZE = 10,
  parameter int WORD_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a_req,
  input  logic                 a_we,
  input  logic [ADDR_SIZE-1:0] a_addr,
  input  logic [WORD_SIZE-1:0] a_wdata,
  output logic                 a_done,
  output logic [WORD_SIZE-1:0] a_rdata,
  input  logic                 b_req,
  input  logic                 b_we,
  input  logic [ADDR_SIZE-1:0] b_addr,
  input  logic [WORD_SIZE-1:0] b_wdata,
  output logic                 b_done,
  output logic [WORD_SIZE-1:0] b_rdata,
  output logic [ADDR_SIZE-1:0] mem_address,
  output logic [WORD_SIZE-1:0] mem_data_in,
  output logic                 mem_write,
  output logic                 mem_select,
  output logic                 mem_read,
  input  logic [WORD_SIZE-1:0] mem_data_out,
  output logic                 busy
);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;
  state_t state;
  logic owner_b, lat_we, grant_b;
`ifdef ARB_FIXED_PRIO_EN
  assign grant_b = !a_req;
`else
  logic prio_b;
  assign grant_b = b_req && (!a_req || prio_b);
`endif
  // mem_address/mem_data_in double as the latched request fields, loaded at the grant edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner_b     <= 1'b0;
      lat_we      <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
      mem_write   <= 1'b0;
      mem_select  <= 1'b0;
      mem_read    <= 1'b0;
      a_done      <= 1'b0;
      b_done      <= 1'b0;
      a_rdata     <= '0;
      b_rdata     <= '0;
      busy        <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      prio_b      <= 1'b0;
`endif
    end else begin
      a_done <= 1'b0;
      b_done <= 1'b0;
      case (state)
        IDLE: if (a_req || b_req) begin
          state       <= SETUP;
          owner_b     <= grant_b;
          lat_we      <= grant_b ? b_we : a_we;
          mem_address <= grant_b ? b_addr : a_addr;
          mem_data_in <= grant_b ? b_wdata : a_wdata;
          mem_select  <= 1'b1;
          busy        <= 1'b1;
        end
        SETUP: begin
          state     <= STROBE;
          mem_write <= lat_we;
          mem_read  <= !lat_we;
        end
        STROBE: begin
          state      <= DONE;
          mem_write  <= 1'b0;
          mem_read   <= 1'b0;
          mem_select <= 1'b0;
          a_done     <= !owner_b;
          b_done     <= owner_b;
          a_rdata    <= (!lat_we && !owner_b) ? mem_data_out : a_rdata;
          b_rdata    <= (!lat_we && owner_b) ? mem_data_out : b_rdata;
`ifndef ARB_FIXED_PRIO_EN
          prio_b     <= !owner_b;
`endif
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed table, corner sequences and randomized transaction-level checking of sram_arbiter
module tb_sram_arbiter;
`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic req_v [2], we_v [2];
  logic [9:0] addr_v [2];
  logic [7:0] wdata_v [2];
  logic a_done, b_done, mem_write, mem_select, mem_read, busy;
  logic [7:0] a_rdata, b_rdata, mem_data_in, mem_data_out;
  logic [9:0] mem_address;
  logic [7:0] sram [1024];
  logic [7:0] mm [1024];
  logic [7:0] exp_a, exp_b;
  int tests = 0, fails = 0;
  int m_e, m_ge, m_nf, d;
  bit m_act, m_own, m_we, m_ptr;
  logic [9:0] m_addr;
  logic [7:0] m_wd;
  typedef struct packed {
    logic p, we;
    logic [9:0] addr;
    logic [7:0] wd, rd;
    logic drop;
  } vec_t;
  vec_t vt [7];

  sram_arbiter dut (
    .clk(clk), .rst(rst),
    .a_req(req_v[0]), .a_we(we_v[0]), .a_addr(addr_v[0]), .a_wdata(wdata_v[0]), .a_done(a_done), .a_rdata(a_rdata),
    .b_req(req_v[1]), .b_we(we_v[1]), .b_addr(addr_v[1]), .b_wdata(wdata_v[1]), .b_done(b_done), .b_rdata(b_rdata),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_write(mem_write), .mem_select(mem_select),
    .mem_read(mem_read), .mem_data_out(mem_data_out), .busy(busy)
  );

  always #5 clk = ~clk;
  assign mem_data_out = sram[mem_address];
  always @(posedge clk) if (mem_select && mem_write) sram[mem_address] <= mem_data_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic new_req(input int p);
    req_v[p] = 1'b1;
    we_v[p] = 1'($urandom_range(1));
    addr_v[p] = $urandom_range(3) == 0 ? 10'(1023 - $urandom_range(3)) : 10'($urandom_range(15));
    wdata_v[p] = 8'($urandom);
  endtask

  task automatic access(input vec_t v);
    req_v[v.p] = 1'b1; we_v[v.p] = v.we; addr_v[v.p] = v.addr; wdata_v[v.p] = v.wd;
    tick;
    chk("setup_sel", 32'(mem_select), 1);
    chk("setup_strobes", 32'({mem_write, mem_read}), 0);
    chk("setup_addr", 32'(mem_address), 32'(v.addr));
    chk("setup_busy", 32'(busy), 1);
    we_v[v.p] = !v.we; addr_v[v.p] = ~v.addr; wdata_v[v.p] = ~v.wd;
    if (v.drop) req_v[v.p] = 1'b0;
    tick;
    chk("strobe_sel", 32'(mem_select), 1);
    chk("strobe_write", 32'(mem_write), 32'(v.we));
    chk("strobe_read", 32'(mem_read), 32'(!v.we));
    chk("strobe_addr", 32'(mem_address), 32'(v.addr));
    chk("strobe_data", 32'(mem_data_in), 32'(v.wd));
    tick;
    chk("done_owner", 32'(v.p ? b_done : a_done), 1);
    chk("done_other", 32'(v.p ? a_done : b_done), 0);
    chk("done_pins", 32'({mem_select, mem_write, mem_read}), 0);
    chk("done_busy", 32'(busy), 1);
    if (!v.we && v.p) exp_b = v.rd;
    if (!v.we && !v.p) exp_a = v.rd;
    chk("rdata_a", 32'(a_rdata), 32'(exp_a));
    chk("rdata_b", 32'(b_rdata), 32'(exp_b));
    req_v[v.p] = 1'b0;
    tick;
    chk("idle_busy", 32'(busy), 0);
    chk("idle_done", 32'({a_done, b_done}), 0);
  endtask

  initial begin
    for (int p = 0; p < 2; p++) begin
      req_v[p] = 1'b0; we_v[p] = 1'b0; addr_v[p] = '0; wdata_v[p] = '0;
    end
    exp_a = '0; exp_b = '0;
    vt = '{
      '{1'b0, 1'b1, 10'd5,    8'hA5, 8'h00, 1'b0},
      '{1'b0, 1'b0, 10'd5,    8'h00, 8'hA5, 1'b0},
      '{1'b1, 1'b1, 10'd1023, 8'h3C, 8'h00, 1'b1},
      '{1'b0, 1'b0, 10'd1023, 8'h00, 8'h3C, 1'b1},
      '{1'b1, 1'b0, 10'd5,    8'h00, 8'hA5, 1'b0},
      '{1'b0, 1'b1, 10'd0,    8'h5A, 8'h00, 1'b0},
      '{1'b1, 1'b0, 10'd0,    8'h00, 8'h5A, 1'b0}
    };
    tick; tick;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'({a_done, b_done}), 0);
    chk("rst_strobes", 32'({mem_select, mem_write, mem_read}), 0);
    chk("rst_addr", 32'(mem_address), 0);
    chk("rst_data", 32'(mem_data_in), 0);
    chk("rst_rdata", 32'({a_rdata, b_rdata}), 0);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) access(vt[i]);

    // simultaneous held reads: alternation (or A-only under fixed priority), then B once A drops
    rst = 1'b1; tick; rst = 1'b0;
    exp_a = '0; exp_b = '0;
    req_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 10'd5;
    req_v[1] = 1'b1; we_v[1] = 1'b0; addr_v[1] = 10'd0;
    for (int k = 0; k <= 18; k++) begin
      tick;
      chk($sformatf("alt_a_done[%0d]", k), 32'(a_done), 32'(k == 2 || k == 10 || (FIXED && (k == 6 || k == 14))));
      chk($sformatf("alt_b_done[%0d]", k), 32'(b_done), 32'((!FIXED && (k == 6 || k == 14)) || k == 18));
      if (k == 14) req_v[0] = 1'b0;
    end
    req_v[1] = 1'b0;
    tick;

    // reset while a write is strobing
    req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 10'd7; wdata_v[0] = 8'h11;
    tick; tick;
    chk("pre_rst_write", 32'(mem_write), 1);
    rst = 1'b1; req_v[0] = 1'b0;
    tick;
    chk("midrst_pins", 32'({mem_select, mem_write, mem_read}), 0);
    chk("midrst_done", 32'({a_done, b_done}), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_addr", 32'(mem_address), 0);
    rst = 1'b0;
    tick;
    chk("postrst_done", 32'({a_done, b_done}), 0);
    chk("postrst_busy", 32'(busy), 0);

    // randomized traffic against a transaction-level model
    rst = 1'b1; tick; rst = 1'b0;
    for (int i = 0; i < 1024; i++) mm[i] = sram[i];
    exp_a = '0; exp_b = '0;
    m_e = 0; m_act = 1'b0; m_ptr = 1'b0; m_nf = 0; m_ge = 0; d = 0;
    for (int n = 0; n < 2000; n++) begin
      @(posedge clk);
      if (m_act && m_e - m_ge >= 3) m_act = 1'b0;
      if (!m_act && m_e >= m_nf && (req_v[0] || req_v[1])) begin
        m_own = FIXED ? !req_v[0] : ((req_v[0] && req_v[1]) ? m_ptr : req_v[1]);
        m_we = we_v[m_own]; m_addr = addr_v[m_own]; m_wd = wdata_v[m_own];
        m_ge = m_e; m_nf = m_e + 4; m_act = 1'b1;
      end
      d = m_e - m_ge;
      if (m_act && d == 2) begin
        if (m_we) mm[m_addr] = m_wd;
        else if (m_own) exp_b = mm[m_addr];
        else exp_a = mm[m_addr];
        m_ptr = !m_own;
      end
      #1;
      chk("rnd_busy", 32'(busy), 32'(m_act));
      chk("rnd_sel", 32'(mem_select), 32'(m_act && d <= 1));
      chk("rnd_write", 32'(mem_write), 32'(m_act && d == 1 && m_we));
      chk("rnd_read", 32'(mem_read), 32'(m_act && d == 1 && !m_we));
      chk("rnd_a_done", 32'(a_done), 32'(m_act && d == 2 && !m_own));
      chk("rnd_b_done", 32'(b_done), 32'(m_act && d == 2 && m_own));
      chk("rnd_a_rdata", 32'(a_rdata), 32'(exp_a));
      chk("rnd_b_rdata", 32'(b_rdata), 32'(exp_b));
      if (m_act) begin
        chk("rnd_addr", 32'(mem_address), 32'(m_addr));
        chk("rnd_wdata", 32'(mem_data_in), 32'(m_wd));
      end
      for (int p = 0; p < 2; p++) begin
        if (m_act && m_own == 1'(p) && d < 2) begin
          if ($urandom_range(3) == 0) begin
            we_v[p] = 1'($urandom); addr_v[p] = 10'($urandom); wdata_v[p] = 8'($urandom);
          end
          if ($urandom_range(7) == 0) req_v[p] = 1'b0;
        end else if (m_act && m_own == 1'(p) && d == 2) begin
          if ($urandom_range(1) == 1) new_req(p);
          else req_v[p] = 1'b0;
        end else if (!req_v[p] && $urandom_range(2) == 0) new_req(p);
      end
      m_e++;
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
